// File: rtl/calculate2_solver.sv
// Inverse of OUT = 3a + 4b + 5c: sequential search, one (b,c) candidate per clock, c-major order.
// Optional macro SOLVER_ITER_CNT_EN adds the iter_cnt candidate counter output.
module calculate2_solver #(
  parameter int W_N   = 6,
  parameter int W_OUT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W_OUT-1:0] target,
  input  logic [1:0]       MODE,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [W_N-1:0]   N0,
  output logic [W_N-1:0]   N1,
  output logic [W_N-1:0]   N2,
  output logic [W_N-1:0]   N3,
  output logic [W_N-1:0]   N4,
  output logic [W_N-1:0]   N5
`ifdef SOLVER_ITER_CNT_EN
  ,
  output logic [2*W_N:0]   iter_cnt
`endif
);

  localparam int RW = W_OUT + 2;
  localparam logic [W_N-1:0]   OP_MAX = '1;
  localparam logic [RW-1:0]    Q_MAX  = RW'(2**W_N - 1);
  localparam logic [W_OUT-1:0] T_MAX  = W_OUT'(12 * (2**W_N - 1));

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t           state, state_nx;
  logic [W_OUT-1:0] tgt;
  logic             mode_hi;
  logic             reject;
  logic [W_N-1:0]   b, c, b_nx, c_nx;
  logic             finish, hit_take;

  // MODE[0] is reserved; it is read here only so it is not left dangling.
  logic unused_mode;
  assign unused_mode = MODE[0];

  // Residual for the current candidate, signed and wide enough that 4M + 5M never wraps.
  logic [RW-1:0]        b4, c5;
  logic signed [RW-1:0] rem;
  logic [RW-1:0]        rem_u, quo, mdl;
  logic                 hit, rem_neg;

  always_comb begin
    b4      = RW'(b) << 2;
    c5      = (RW'(c) << 2) + RW'(c);
    rem     = $signed(RW'(tgt)) - $signed(b4) - $signed(c5);
    rem_neg = rem[RW-1];
    rem_u   = rem;
    quo     = rem_u / RW'(3);
    mdl     = rem_u % RW'(3);
    hit     = !rem_neg && (mdl == '0) && (quo <= Q_MAX);
  end

  // NOTE: every variable assigned in this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_nx = state;
    b_nx     = b;
    c_nx     = c;
    finish   = 1'b0;
    hit_take = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = SEARCH;
          b_nx     = '0;
          c_nx     = '0;
        end
      end
      SEARCH: begin
        if (reject) begin
          finish = 1'b1;
        end else if (hit) begin
          finish   = 1'b1;
          hit_take = 1'b1;
        end else if (rem_neg) begin
          // Larger b only lowers rem further, so skip to the next c.
          if (b == '0 || c == OP_MAX) begin
            finish = 1'b1;
          end else begin
            b_nx = '0;
            c_nx = c + 1'b1;
          end
        end else if (b != OP_MAX) begin
          b_nx = b + 1'b1;
        end else if (c == OP_MAX) begin
          finish = 1'b1;
        end else begin
          b_nx = '0;
          c_nx = c + 1'b1;
        end
        if (finish) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy = (state != IDLE);
    done = (state == DONE);
  end

  logic [W_N-1:0] a_val;
  assign a_val = quo[W_N-1:0];

`ifdef SOLVER_ITER_CNT_EN
  logic [2*W_N:0] cnt;
  assign iter_cnt = cnt;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tgt     <= '0;
      mode_hi <= 1'b0;
      reject  <= 1'b0;
      b       <= '0;
      c       <= '0;
      found   <= 1'b0;
      N0      <= '0;
      N1      <= '0;
      N2      <= '0;
      N3      <= '0;
      N4      <= '0;
      N5      <= '0;
`ifdef SOLVER_ITER_CNT_EN
      cnt     <= '0;
`endif
    end else begin
      state <= state_nx;
      b     <= b_nx;
      c     <= c_nx;
      if (state == IDLE && start) begin
        tgt     <= target;
        mode_hi <= MODE[1];
        reject  <= (target > T_MAX);
`ifdef SOLVER_ITER_CNT_EN
        cnt     <= '0;
`endif
      end
`ifdef SOLVER_ITER_CNT_EN
      if (state == SEARCH) cnt <= cnt + 1'b1;
`endif
      if (finish) begin
        found <= hit_take;
        N0    <= (hit_take &&  mode_hi) ? a_val : '0;
        N1    <= (hit_take &&  mode_hi) ? b     : '0;
        N2    <= (hit_take &&  mode_hi) ? c     : '0;
        N3    <= (hit_take && !mode_hi) ? a_val : '0;
        N4    <= (hit_take && !mode_hi) ? b     : '0;
        N5    <= (hit_take && !mode_hi) ? c     : '0;
      end
    end
  end

endmodule

// File: tb/tb_calculate2_solver.sv
// Scoreboard bench for calculate2_solver: expected results queued at start, compared at done.
module tb_calculate2_solver;

  localparam int W_N   = 6;
  localparam int W_OUT = 10;
  localparam int M     = 63;
  localparam int BOUND = 5000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [W_OUT-1:0] target = '0;
  logic [1:0]       MODE = '0;
  logic             busy, done, found;
  logic [W_N-1:0]   N0, N1, N2, N3, N4, N5;
`ifdef SOLVER_ITER_CNT_EN
  logic [2*W_N:0]   iter_cnt;
`endif

  calculate2_solver #(.W_N(W_N), .W_OUT(W_OUT)) dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .MODE(MODE),
    .busy(busy), .done(done), .found(found),
    .N0(N0), .N1(N1), .N2(N2), .N3(N3), .N4(N4), .N5(N5)
`ifdef SOLVER_ITER_CNT_EN
    , .iter_cnt(iter_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [6*W_N-1:0] nvec;
  assign nvec = {N5, N4, N3, N2, N1, N0};

  typedef struct {
    logic             found;
    logic [6*W_N-1:0] nv;
    int               cycles;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Reference search following the documented candidate order and stop rules.
  function automatic exp_t model(int tgt, logic mode_hi);
    exp_t e;
    int b, c, a, rem;
    bit stop;
    e.found = 1'b0; e.nv = '0; e.cycles = 0;
    a = 0; b = 0; c = 0;
    if (tgt > 12 * M) begin
      e.cycles = 1;
      return e;
    end
    stop = 1'b0;
    while (!stop) begin
      e.cycles++;
      rem = tgt - 4 * b - 5 * c;
      if (rem >= 0 && rem % 3 == 0 && rem / 3 <= M) begin
        e.found = 1'b1; a = rem / 3; stop = 1'b1;
      end else if (rem < 0) begin
        if (b == 0 || c == M) stop = 1'b1;
        else begin c++; b = 0; end
      end else if (b < M) b++;
      else if (c == M) stop = 1'b1;
      else begin c++; b = 0; end
    end
    if (e.found) begin
      if (mode_hi) e.nv = {18'b0, W_N'(c), W_N'(b), W_N'(a)};
      else         e.nv = {W_N'(c), W_N'(b), W_N'(a), 18'b0};
    end
    return e;
  endfunction

  task automatic issue(int tgt, logic [1:0] mode);
    @(negedge clk);
    start  = 1'b1;
    target = W_OUT'(tgt);
    MODE   = mode;
    sb.push_back(model(tgt, mode[1]));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done (bounded), optionally pulsing start at candidate inject_at, then compares.
  task automatic wait_result(string name, int inject_at);
    exp_t e;
    int k;
    bit busy_bad;
    e = sb.pop_front();
    k = 0;
    busy_bad = 1'b0;
    while (!done && k < BOUND) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (k == inject_at) begin start = 1'b1; target = '0; MODE = 2'b00; end
      if (k == inject_at + 1) start = 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    checks++;
    if (busy_bad) begin
      failures++; $display("FAIL %s busy_search: busy dropped during search, required 1", name);
    end
    checks++;
    if (done !== 1'b1 || k !== e.cycles) begin
      failures++; $display("FAIL %s done_timing: done=%b at cycle %0d, required done=1 at cycle %0d", name, done, k, e.cycles);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL %s busy_done: got %b required 1", name, busy);
    end
    checks++;
    if (found !== e.found) begin
      failures++; $display("FAIL %s found: got %b required %b", name, found, e.found);
    end
    checks++;
    if (nvec !== e.nv) begin
      failures++; $display("FAIL %s slots: got N5..N0=%h required %h", name, nvec, e.nv);
    end
`ifdef SOLVER_ITER_CNT_EN
    checks++;
    if (iter_cnt !== (2*W_N+1)'(e.cycles)) begin
      failures++; $display("FAIL %s iter_cnt: got %0d required %0d", name, iter_cnt, e.cycles);
    end
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s after_done: done=%b busy=%b required 0 0", name, done, busy);
    end
    checks++;
    if (found !== e.found || nvec !== e.nv) begin
      failures++; $display("FAIL %s hold: found=%b slots=%h required %b %h", name, found, nvec, e.found, e.nv);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || nvec !== '0) begin
      failures++; $display("FAIL reset: busy=%b done=%b found=%b slots=%h required all 0", busy, done, found, nvec);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    issue(0, 2'b10); wait_result("t1_zero", -10);
    issue(4, 2'b00); wait_result("t2_low_slots", -10);
    issue(1, 2'b10); wait_result("t3_no_solution", -10);
  endtask

  task automatic test_worst_case();
    issue(756, 2'b10); wait_result("t4_max", 50);
  endtask

  task automatic test_reject();
    issue(757, 2'b10); wait_result("t5_reject", -10);
  endtask

  task automatic test_back_to_back();
    int t;
    logic [1:0] m;
    for (int i = 0; i < 6; i++) begin
      t = $urandom_range(0, 12 * M);
      m = 2'($urandom_range(0, 3));
      issue(t, m);
      wait_result($sformatf("rand%0d_t%0d", i, t), -10);
    end
  endtask

  task automatic test_reset_midsearch();
    exp_t e;
    int k;
    issue(13, 2'b00); wait_result("t6_pre", -10);
    issue(756, 2'b10);
    e = sb.pop_front();
    k = 0;
    while (k < 100 && !done) begin
      @(negedge clk);
      k++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || nvec !== '0) begin
      failures++; $display("FAIL t6_reset_mid: busy=%b done=%b found=%b slots=%h required all 0", busy, done, found, nvec);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL t6_post_reset_idle: busy=%b done=%b required 0 0 (expected cycles %0d)", busy, done, e.cycles);
    end
    issue(3, 2'b10); wait_result("t6_restart", -10);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_worst_case();
    test_reject();
    test_back_to_back();
    test_reset_midsearch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
